// File: rtl/btn_pkg.sv
// ---------------------------------------------------------------------------
// btn_pkg
// Shared definitions for the push-button conditioning blocks.
//   - state_t  : FSM state encoding (ST_IDLE, ST_PRESSED, ST_HOLD)
//   - *_DEF    : default timing constants for a 100 MHz clock
// ---------------------------------------------------------------------------
package btn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HOLD    = 2'd2
  } state_t;

  localparam int DEB_CYCLES_DEF    = 1_000_000;   // 10 ms
  localparam int HOLD_CYCLES_DEF   = 50_000_000;  // 500 ms
  localparam int REPEAT_CYCLES_DEF = 10_000_000;  // 100 ms

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Generic two-stage synchronizer for asynchronous level inputs
// (buttons, switches). Synchronous active-low reset clears both stages.
// Ports:
//   clk_i   in   clock
//   rstn_i  in   synchronous active-low reset
//   d_i     in   asynchronous input  [WIDTH-1:0]
//   q_o     out  synchronized output [WIDTH-1:0] (second stage)
// ---------------------------------------------------------------------------
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/button_cond.sv
// ---------------------------------------------------------------------------
// button_cond
// Conditions one raw push-button: 2-FF synchronizer, debounce, press and
// release strobes, long-hold level and optional auto-repeat strobes.
// Optional feature macro: BUTTON_COND_AUTOREPEAT_EN
//   defined   -> repeat_o pulses on HOLD entry, then every REPEAT_CYCLES
//   undefined -> no repeat counter, repeat_o tied low
// Ports:
//   clk100_i   in   100 MHz system clock
//   rstn_i     in   synchronous active-low reset
//   btn_i      in   raw button, active-high, asynchronous and bouncy
//   level_o    out  debounced level
//   press_o    out  one-cycle strobe on accepted 0->1
//   release_o  out  one-cycle strobe on accepted 1->0
//   hold_o     out  high while the press has lasted >= HOLD_CYCLES
//   repeat_o   out  one-cycle auto-repeat strobe
// ---------------------------------------------------------------------------
module button_cond
  import btn_pkg::*;
#(
  parameter int DEB_CYCLES    = DEB_CYCLES_DEF,
  parameter int HOLD_CYCLES   = HOLD_CYCLES_DEF,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
  input  logic clk100_i,
  input  logic rstn_i,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic hold_o,
  output logic repeat_o
);

  localparam int DW = $clog2(DEB_CYCLES);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);

  // Parameter sanity checks at elaboration.
  if (DEB_CYCLES < 2) begin : g_bad_deb
    $error("button_cond: DEB_CYCLES must be >= 2");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("button_cond: HOLD_CYCLES must be >= 1");
  end
  if (REPEAT_CYCLES < 1) begin : g_bad_rep
    $error("button_cond: REPEAT_CYCLES must be >= 1");
  end

  logic          sync_q;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          level_q, level_d;
  logic          differ, accept, rise, fall;

  state_t        state_q;
  logic [HW-1:0] hcnt_q;
  logic          press_q, release_q, hold_q;

  sync_2ff #(.WIDTH(1)) u_sync (
    .clk_i  (clk100_i),
    .rstn_i (rstn_i),
    .d_i    (btn_i),
    .q_o    (sync_q)
  );

  // Debounce: the synchronized input must differ from the accepted level for
  // DEB_CYCLES consecutive cycles; any agreeing cycle restarts the count.
  always_comb begin
    differ  = sync_q ^ level_q;
    accept  = differ && (dcnt_q == DEB_MAX);
    dcnt_d  = (!differ || accept) ? '0 : dcnt_q + 1'b1;
    level_d = level_q ^ accept;
  end

  assign rise = accept & ~level_q;
  assign fall = accept &  level_q;

  always_ff @(posedge clk100_i) begin
    if (!rstn_i) begin
      dcnt_q  <= '0;
      level_q <= 1'b0;
    end else begin
      dcnt_q  <= dcnt_d;
      level_q <= level_d;
    end
  end

`ifdef BUTTON_COND_AUTOREPEAT_EN
  localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RW-1:0] REP_MAX = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0] rcnt_q;
  logic          rep_q;
`endif

  // Press/hold FSM. A fall is checked first in every active state so that a
  // release always wins over hold entry or a repeat strobe in the same cycle.
  always_ff @(posedge clk100_i) begin
    if (!rstn_i) begin
      state_q   <= ST_IDLE;
      hcnt_q    <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      hold_q    <= 1'b0;
`ifdef BUTTON_COND_AUTOREPEAT_EN
      rcnt_q    <= '0;
      rep_q     <= 1'b0;
`endif
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
`ifdef BUTTON_COND_AUTOREPEAT_EN
      rep_q     <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (rise) begin
            state_q <= ST_PRESSED;
            press_q <= 1'b1;
            hcnt_q  <= '0;
          end
        end
        ST_PRESSED: begin
          if (fall) begin
            state_q   <= ST_IDLE;
            release_q <= 1'b1;
            hcnt_q    <= '0;
          end else if (hcnt_q == HOLD_MAX) begin
            // hcnt_q stays at HOLD_MAX from here on (saturated).
            state_q <= ST_HOLD;
            hold_q  <= 1'b1;
`ifdef BUTTON_COND_AUTOREPEAT_EN
            rcnt_q  <= '0;
            rep_q   <= 1'b1;
`endif
          end else begin
            hcnt_q <= hcnt_q + 1'b1;
          end
        end
        ST_HOLD: begin
          if (fall) begin
            state_q   <= ST_IDLE;
            release_q <= 1'b1;
            hold_q    <= 1'b0;
            hcnt_q    <= '0;
`ifdef BUTTON_COND_AUTOREPEAT_EN
            rcnt_q    <= '0;
`endif
          end else begin
`ifdef BUTTON_COND_AUTOREPEAT_EN
            if (rcnt_q == REP_MAX) begin
              rcnt_q <= '0;
              rep_q  <= 1'b1;
            end else begin
              rcnt_q <= rcnt_q + 1'b1;
            end
`endif
          end
        end
        default: begin
          state_q <= ST_IDLE;
          hold_q  <= 1'b0;
          hcnt_q  <= '0;
        end
      endcase
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign hold_o    = hold_q;
`ifdef BUTTON_COND_AUTOREPEAT_EN
  assign repeat_o  = rep_q;
`else
  assign repeat_o  = 1'b0;
`endif

endmodule

// File: tb/tb_button_cond.sv
// ---------------------------------------------------------------------------
// tb_button_cond
// Directed bench for button_cond with DEB_CYCLES=4, HOLD_CYCLES=20,
// REPEAT_CYCLES=8. Output vector order: {level, press, release, hold, repeat}.
// Expected repeat behaviour follows BUTTON_COND_AUTOREPEAT_EN.
// ---------------------------------------------------------------------------
module tb_button_cond;

  localparam int DEB  = 4;
  localparam int HOLD = 20;
  localparam int REP  = 8;
  localparam int LAT  = DEB + 1;   // edge index at which a new level is accepted

  logic clk = 1'b0;
  logic rstn;
  logic btn;
  logic level, press, rel, hold, rpt;

  int checks = 0;
  int passed = 0;

  logic [4:0] exp_q[$];
  string      tag_q[$];

  button_cond #(
    .DEB_CYCLES    (DEB),
    .HOLD_CYCLES   (HOLD),
    .REPEAT_CYCLES (REP)
  ) dut (
    .clk100_i  (clk),
    .rstn_i    (rstn),
    .btn_i     (btn),
    .level_o   (level),
    .press_o   (press),
    .release_o (rel),
    .hold_o    (hold),
    .repeat_o  (rpt)
  );

  always #5 clk = ~clk;

  // Expected outputs at step i of a clean press: btn rises before edge 0 and
  // falls before edge r (r large = still held).
  function automatic logic [4:0] exp_press(input int i, input int r);
    logic lv, pr, rl, hd, rp;
    lv = (i >= LAT) && (i < r + LAT);
    pr = (i == LAT);
    rl = (i == r + LAT);
    hd = (i >= LAT + HOLD) && (i < r + LAT);
    rp = 1'b0;
`ifdef BUTTON_COND_AUTOREPEAT_EN
    if (hd && (((i - LAT - HOLD) % REP) == 0)) rp = 1'b1;
`endif
    return {lv, pr, rl, hd, rp};
  endfunction

  // Drive one cycle of stimulus, push its expectation, compare after the edge.
  task automatic step(input logic b, input logic r, input logic [4:0] e,
                      input string tag);
    logic [4:0] obs, ex;
    string      t;
    @(negedge clk);
    btn  = b;
    rstn = r;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    obs = {level, press, rel, hold, rpt};
    ex  = exp_q.pop_front();
    t   = tag_q.pop_front();
    checks++;
    assert (obs === ex) passed++;
    else $error("FAIL %s: observed %b expected %b", t, obs, ex);
  endtask

  initial begin
    rstn = 1'b0;
    btn  = 1'b1;

    // 1: reset with button held, then release reset while still held
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 5'b0, $sformatf("s1_reset[%0d]", i));
    for (int i = 0; i < 20; i++)
      step(i < 12, 1'b1, exp_press(i, 12), $sformatf("s1_press[%0d]", i));

    // 2: bounce every 2 cycles never gets accepted
    for (int i = 0; i < 40; i++)
      step((i < 30) ? logic'((i / 2) % 2) : 1'b0, 1'b1, 5'b0,
           $sformatf("s2_bounce[%0d]", i));

    // 3: clean 10-cycle press
    for (int i = 0; i < 20; i++)
      step(i < 10, 1'b1, exp_press(i, 10), $sformatf("s3_short[%0d]", i));

    // 4/6: press held 60 cycles -> hold, repeats (if built), release
    for (int i = 0; i < 70; i++)
      step(i < 60, 1'b1, exp_press(i, 60), $sformatf("s4_long[%0d]", i));

    // 5: reset during HOLD at t+30 with button still held
    for (int i = 0; i < LAT + 30; i++)
      step(1'b1, 1'b1, exp_press(i, 1000), $sformatf("s5_hold[%0d]", i));
    step(1'b1, 1'b0, 5'b0, "s5_reset_edge");
    step(1'b1, 1'b0, 5'b0, "s5_reset_hold");
    for (int i = 0; i < 16; i++)
      step(i < 8, 1'b1, exp_press(i, 8), $sformatf("s5_repress[%0d]", i));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
